// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key event scanner
// Optional feature macro: KEY_EVENTS_TIMESTAMP_EN (adds a 16-bit timestamp to each event).
package key_pkg;

    localparam int KEY_CODE_W = 6;

    typedef enum logic {
        SCAN  = 1'b0,
        STALL = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  press;
`ifdef KEY_EVENTS_TIMESTAMP_EN
        logic [15:0]           tstamp;
`endif
    } key_evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - first-word-fall-through event queue with registered outputs
// Ports: clk_i, rst_i (sync, active-high); push_i/wdata_i write side (push ignored when full);
//        full_o; valid_o/ready_i/rdata_o head side; count_o = entries held.
module key_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     full_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    remain;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the count at the start of the cycle, so a pop in
    // the same cycle never frees a slot for a push.
    assign full_o  = (count == FULL_CNT);
    assign count_o = count;

    always_comb begin
        do_push    = push_i && !full_o;
        do_pop     = valid_o && ready_i;
        rd_next    = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        remain     = count - CW'(do_pop);
        count_next = remain + CW'(do_push);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr  <= rd_next;
            count   <= count_next;
            valid_o <= (count_next != '0);
            // When no older entry survives this cycle the new head is the
            // word being written now, which is not yet readable from mem.
            if (remain == '0) begin
                rdata_o <= wdata_i;
            end else begin
                rdata_o <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/key_events.sv
// rtl/key_events.sv - scans a debounced key vector and queues press/release events
// Optional feature macro: KEY_EVENTS_TIMESTAMP_EN (adds evt_time_o and a 16-bit cycle counter).
// Ports: clk_i, rst_i (sync, active-high); keys_i key levels (1 = pressed);
//        evt_valid_o/evt_ready_i handshake; evt_code_o, evt_press_o[, evt_time_o] head event;
//        evt_count_o queued event count.
module key_events
    import key_pkg::*;
#(
    parameter int KEYS       = 61,
    parameter int FIFO_DEPTH = 16,
    parameter int CODE_W     = KEY_CODE_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [KEYS-1:0]               keys_i,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [CODE_W-1:0]             evt_code_o,
    output logic                          evt_press_o,
`ifdef KEY_EVENTS_TIMESTAMP_EN
    output logic [15:0]                   evt_time_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   evt_count_o
);

`ifdef KEY_EVENTS_TIMESTAMP_EN
    localparam int PW = CODE_W + 1 + 16;
`else
    localparam int PW = CODE_W + 1;
`endif
    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(KEYS - 1);

    logic [KEYS-1:0]   prev;
    logic [CODE_W-1:0] idx;
    logic [CODE_W-1:0] next_idx;
    scan_state_t       state;
    logic              key_now;
    logic              changed;
    logic              fifo_full;
    logic              push;
    logic [PW-1:0]     push_data;
    logic [PW-1:0]     head_data;

`ifdef KEY_EVENTS_TIMESTAMP_EN
    logic [15:0] tstamp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tstamp <= '0;
        end else begin
            tstamp <= tstamp + 16'd1;
        end
    end

    assign push_data  = {idx, key_now, tstamp};
    assign evt_time_o = head_data[15:0];
`else
    assign push_data  = {idx, key_now};
`endif

    assign evt_code_o  = head_data[PW-1 -: CODE_W];
    assign evt_press_o = head_data[PW-1-CODE_W];

    always_comb begin
        key_now  = keys_i[idx];
        changed  = (key_now != prev[idx]);
        push     = (state == SCAN) && changed && !fifo_full;
        next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    // A stalled key keeps idx parked on it and prev untouched, so the
    // change is re-examined (and sampled afresh) once space frees up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev  <= '0;
            idx   <= '0;
            state <= SCAN;
        end else begin
            case (state)
                SCAN: begin
                    if (!changed) begin
                        idx <= next_idx;
                    end else if (fifo_full) begin
                        state <= STALL;
                    end else begin
                        prev[idx] <= key_now;
                        idx       <= next_idx;
                    end
                end
                STALL: begin
                    if (!fifo_full) begin
                        state <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (push_data),
        .full_o  (fifo_full),
        .valid_o (evt_valid_o),
        .ready_i (evt_ready_i),
        .rdata_o (head_data),
        .count_o (evt_count_o)
    );

endmodule

// File: tb/tb_key_events.sv
// tb/tb_key_events.sv - self-checking bench for key_events (scoreboard + vector table)
module tb_key_events;
    import key_pkg::*;

    localparam int KEYS  = 61;
    localparam int DEPTH = 16;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [KEYS-1:0] keys_i = '0;
    logic            evt_ready_i = 1'b0;
    logic            evt_valid_o;
    logic [5:0]      evt_code_o;
    logic            evt_press_o;
    logic [4:0]      evt_count_o;
`ifdef KEY_EVENTS_TIMESTAMP_EN
    logic [15:0]     evt_time_o;
    logic [15:0]     ts_seen[$];
    logic [15:0]     ts_diff;
`endif

    always #5 clk_i = ~clk_i;

    key_events #(
        .KEYS       (KEYS),
        .FIFO_DEPTH (DEPTH),
        .CODE_W     (6)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .keys_i      (keys_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_code_o  (evt_code_o),
        .evt_press_o (evt_press_o),
`ifdef KEY_EVENTS_TIMESTAMP_EN
        .evt_time_o  (evt_time_o),
`endif
        .evt_count_o (evt_count_o)
    );

    typedef struct {
        int code;
        bit press;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t tbl[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pops happen at the next rising edge; outputs are sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i && evt_valid_o && evt_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_evt: got code %0d press %0d, expected no event",
                         evt_code_o, evt_press_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(evt_code_o) != mon_e.code || evt_press_o != mon_e.press) begin
                    n_fail++;
                    $display("FAIL evt_order: got code %0d press %0d, expected code %0d press %0d",
                             evt_code_o, evt_press_o, mon_e.code, mon_e.press);
                end
            end
`ifdef KEY_EVENTS_TIMESTAMP_EN
            ts_seen.push_back(evt_time_o);
`endif
        end
    end

    task automatic push_exp(input int code, input bit press);
        exp_t e;
        e.code  = code;
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic [KEYS-1:0] k);
        rst_i  = 1'b1;
        keys_i = k;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk_i);
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk_i);
        #1 check({name, "_count_after"}, int'(evt_count_o), 0);
    endtask

    initial begin
        logic [KEYS-1:0] k;
        int lat;

        // Reset state
        evt_ready_i = 1'b1;
        do_reset('0);
        check("rst_valid", int'(evt_valid_o), 0);
        check("rst_count", int'(evt_count_o), 0);
        check("rst_code",  int'(evt_code_o), 0);
        check("rst_press", int'(evt_press_o), 0);

        // Keys held through reset: one press each, scan order
        k = '0;
        k[0] = 1'b1; k[3] = 1'b1; k[60] = 1'b1;
        push_exp(0, 1'b1);
        push_exp(3, 1'b1);
        push_exp(60, 1'b1);
        do_reset(k);
        wait_drain(200, "held_keys");

        // Single-key change table with detection latency bound
        do_reset('0);
        tbl[0] = '{5, 1'b1};  tbl[1] = '{5, 1'b0};
        tbl[2] = '{0, 1'b1};  tbl[3] = '{60, 1'b1};
        tbl[4] = '{60, 1'b0}; tbl[5] = '{0, 1'b0};
        tbl[6] = '{7, 1'b1};  tbl[7] = '{7, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1 keys_i[tbl[i].code] = tbl[i].press;
            push_exp(tbl[i].code, tbl[i].press);
            lat = 0;
            while (!evt_valid_o && lat < 70) begin
                @(negedge clk_i);
                lat++;
            end
            n_checks++;
            if (lat > 62) begin
                n_fail++;
                $display("FAIL latency[%0d]: got %0d cycles, expected <= 62", i, lat);
            end
            wait_drain(100, "table");
        end

        // Short glitch on key 7 while the scanner is around index 30
        do_reset('0);
        repeat (30) @(posedge clk_i);
        #1 keys_i[7] = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 keys_i[7] = 1'b0;
        repeat (80) @(posedge clk_i);
        #1 check("glitch_count", int'(evt_count_o), 0);
        check("glitch_valid", int'(evt_valid_o), 0);

        // Overflow: 20 keys with consumer stalled
        evt_ready_i = 1'b0;
        k = '0;
        for (int i = 10; i < 30; i++) begin
            k[i] = 1'b1;
            push_exp(i, 1'b1);
        end
        do_reset(k);
        repeat (100) @(posedge clk_i);
        #1 check("sat_count", int'(evt_count_o), 16);
        check("sat_state", int'(dut.state), int'(STALL));
        check("sat_head",  int'(evt_code_o), 10);
        evt_ready_i = 1'b1;
        wait_drain(400, "overflow");

        // Reset with events queued discards them
        evt_ready_i = 1'b0;
        k = '0;
        k[0] = 1'b1; k[1] = 1'b1; k[2] = 1'b1; k[3] = 1'b1;
        do_reset(k);
        repeat (70) @(posedge clk_i);
        #1 check("pre_rst_count", int'(evt_count_o), 4);
        rst_i  = 1'b1;
        keys_i = '0;
        @(posedge clk_i);
        #1 check("mid_rst_valid", int'(evt_valid_o), 0);
        check("mid_rst_count", int'(evt_count_o), 0);
        rst_i = 1'b0;
        evt_ready_i = 1'b1;
        repeat (100) @(posedge clk_i);
        #1 check("post_rst_count", int'(evt_count_o), 0);

`ifdef KEY_EVENTS_TIMESTAMP_EN
        // Key 5 pushed at cycle 5, key 44 at cycle 105
        ts_seen.delete();
        push_exp(5, 1'b1);
        push_exp(44, 1'b1);
        k = '0;
        k[5] = 1'b1;
        do_reset(k);
        repeat (50) @(posedge clk_i);
        #1 keys_i[44] = 1'b1;
        wait_drain(200, "ts_pair");
        if (ts_seen.size() >= 2) begin
            ts_diff = ts_seen[1] - ts_seen[0];
            check("ts_diff", int'(ts_diff), 100);
        end else begin
            check("ts_pair_seen", ts_seen.size(), 2);
        end

        // Key 27 pushed at cycle 65480, key 5 at 65580 (stamp wraps to 44)
        ts_seen.delete();
        push_exp(27, 1'b1);
        push_exp(5, 1'b1);
        do_reset('0);
        repeat (65470) @(posedge clk_i);
        #1 keys_i[27] = 1'b1;
        repeat (60) @(posedge clk_i);
        #1 keys_i[5] = 1'b1;
        wait_drain(200, "ts_wrap");
        if (ts_seen.size() >= 2) begin
            ts_diff = ts_seen[1] - ts_seen[0];
            check("ts_wrap_diff", int'(ts_diff), 100);
            check("ts_wrap_first", int'(ts_seen[0]), 65480);
            check("ts_wrap_second", int'(ts_seen[1]), 44);
        end else begin
            check("ts_wrap_seen", ts_seen.size(), 2);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_events.md
KEY_EVENTS -- requirements
Module: key_events

Interface
REQ-001 Parameter KEYS, default 61: width of the debounced key vector consumed.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two, at least 2: event queue entries.
REQ-003 Parameter CODE_W, default 6: key index width; SHALL satisfy 2**CODE_W >= KEYS.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 keys_i  input  KEYS  debounced key levels, 1 = pressed.
REQ-007 evt_valid_o  output  1  head event available.
REQ-008 evt_ready_i  input  1  consumer accepts the head event.
REQ-009 evt_code_o  output  CODE_W  key index of the head event.
REQ-010 evt_press_o  output  1  1 = press, 0 = release.
REQ-011 evt_count_o  output  $clog2(FIFO_DEPTH)+1  queued event count.
REQ-012 evt_time_o  output  16  timestamp of the head event; present only with KEY_EVENTS_TIMESTAMP_EN.

Function
REQ-013 The block SHALL hold a KEYS-bit last-reported state vector, prev.
REQ-014 The scanner SHALL hold an index idx that visits 0..KEYS-1 at one key per cycle, then wraps KEYS-1 -> 0.
REQ-015 FSM states: SCAN and STALL.
REQ-016 SCAN behaviour:
- If keys_i[idx] equals prev[idx]: idx advances.
- If they differ and the FIFO is not full: push {idx, keys_i[idx]}, set prev[idx] <= keys_i[idx], and advance idx.
REQ-017 SCAN, differing key with the FIFO full: go to STALL and hold idx; prev is not updated.
REQ-018 STALL: stay while the FIFO is full; when it is not full, return to SCAN with idx unchanged, so no event is ever lost.
REQ-019 Full is evaluated from the count at the start of the cycle; a pop in the same cycle does not permit a push.
REQ-020 A key that toggles and returns to prev before idx reaches it SHALL produce no event.
REQ-021 The event pushed is the key level sampled in the push cycle.
REQ-022 FIFO output:
- First-word-fall-through with registered outputs.
- An event pushed at cycle t into an empty FIFO has evt_valid_o high at t+1.
REQ-023 A pop occurs when evt_valid_o and evt_ready_i are both high.
- evt_code_o, evt_press_o and evt_time_o SHALL stay stable while evt_valid_o is high and evt_ready_i is low.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
REQ-025 Events SHALL be delivered in push order; pointers wrap modulo FIFO_DEPTH.
REQ-026 Worst-case detection latency: KEYS cycles plus stall time.

Reset
REQ-027 While rst_i is high at a clock edge:
- prev <= 0, idx <= 0, FSM <= SCAN;
- FIFO emptied; evt_valid_o <= 0, evt_count_o <= 0;
- evt_code_o, evt_press_o and evt_time_o <= 0; timestamp counter <= 0.
REQ-028 Reset mid-operation SHALL discard all queued events.
REQ-029 After reset, keys already held SHALL each produce one press event on the first scan.

Configuration
REQ-030 Macro KEY_EVENTS_TIMESTAMP_EN defined:
- A free-running 16-bit cycle counter increments every clock and wraps 0xFFFF -> 0.
- Its value in the push cycle is stored with each event and presented on evt_time_o.
REQ-031 Macro KEY_EVENTS_TIMESTAMP_EN undefined:
- No counter and no timestamp storage exist.
- The evt_time_o port is absent.
- All other behaviour is identical.

Structure
REQ-032 Shared package key_pkg SHALL hold:
- the KEY_CODE_W constant;
- the key_evt_t typedef {code, press, optional time};
- the scanner state enum.
REQ-033 The FIFO SHALL be a separate sub-module, key_evt_fifo, parameterised by depth and payload width.

Verification
REQ-034 Reset with keys_i = 0, then raise bit 5 -> exactly one event {code 5, press 1} within 61 cycles; evt_count_o returns to 0 after the pop.
REQ-035 After reset with keys_i bits 0, 3 and 60 high -> three press events in order 0, 3, 60.
REQ-036 evt_ready_i held low while 20 keys are pressed -> evt_count_o saturates at 16 and the FSM reaches STALL; evt_ready_i then high -> all 20 events delivered, none lost or duplicated.
REQ-037 Bit 7 pulses for 2 cycles while idx is far from 7 -> no event; press then release of bit 7 across scans -> press event followed by release event.
REQ-038 rst_i asserted with 4 events queued -> evt_valid_o low on the next cycle; no stale event appears afterwards.
REQ-039 With KEY_EVENTS_TIMESTAMP_EN defined, two presses pushed 100 cycles apart -> evt_time_o values differ by 100 modulo 65536, including across a counter wrap.
